// File: rtl/sensor_pkg.sv
// Shared types and defaults for the clocked sensor monitor.
package sensor_pkg;

  typedef enum logic [1:0] {StIdle, StPending, StFault, StLatched} state_e;

  localparam logic [3:0] DEF_CRIT_MASK    = 4'b0001;
  localparam logic [3:0] DEF_PARTNER_MASK = 4'b1100;

  // Width needed to hold 0..cycles.
  function automatic int unsigned cnt_width(int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Counts consecutive raw fault samples; done fires on the sample that completes the run.
module sensor_debounce import sensor_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic restart,
  output logic done
);

  localparam int unsigned     CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] Last = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done = raw && !restart && (cnt_q == Last);

  // A clean sample or a completed run returns the count to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !raw || done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sensor_monitor.sv
// Debounced, sticky sensor fault monitor with entry pulse, saturating count and snapshot.
module sensor_monitor import sensor_pkg::*; #(
  parameter int unsigned                   NUM_SENSORS     = 4,
  parameter logic [NUM_SENSORS-1:0]        CRIT_MASK       = NUM_SENSORS'(DEF_CRIT_MASK),
  parameter int unsigned                   PRIMARY_IDX     = 1,
  parameter logic [NUM_SENSORS-1:0]        PARTNER_MASK    = NUM_SENSORS'(DEF_PARTNER_MASK),
  parameter int unsigned                   DEBOUNCE_CYCLES = 4,
  parameter int unsigned                   COUNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic [NUM_SENSORS-1:0] sensor_en,
  input  logic                   clear,
  output logic                   error,
  output logic                   error_pulse,
  output logic [COUNT_W-1:0]     fault_count,
  output logic [NUM_SENSORS-1:0] fault_snapshot
);

  // The primary sensor cannot partner itself.
  localparam logic [NUM_SENSORS-1:0] PartnerEff =
      PARTNER_MASK & ~(NUM_SENSORS'(1) << PRIMARY_IDX);

  state_e                   state_q;
  logic [NUM_SENSORS-1:0]   sens_q;
  logic [NUM_SENSORS-1:0]   snap_q;
  logic [COUNT_W-1:0]       count_q;
  logic                     error_q;
  logic                     pulse_q;
  logic                     raw;
  logic                     restart;
  logic                     done;

  assign raw     = (|(sens_q & CRIT_MASK)) | (sens_q[PRIMARY_IDX] & (|(sens_q & PartnerEff)));
  assign restart = (state_q == StFault) || (state_q == StLatched);

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw),
    .restart(restart),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sens_q  <= '0;
      snap_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sens_q  <= sensors & sensor_en;
      pulse_q <= 1'b0;
      unique case (state_q)
        StIdle, StPending: begin
          if (done) begin
            state_q <= StFault;
            error_q <= 1'b1;
            pulse_q <= 1'b1;
            snap_q  <= sens_q;
            if (count_q != '1) begin
              count_q <= count_q + COUNT_W'(1);
            end
          end else if (raw) begin
            state_q <= StPending;
          end else begin
            state_q <= StIdle;
          end
        end
        StFault: begin
          if (!raw) begin
            state_q <= StLatched;
          end
        end
        StLatched: begin
          // A returning fault wins over a simultaneous acknowledge.
          if (raw) begin
            state_q <= StFault;
          end else if (clear) begin
            state_q <= StIdle;
            error_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  assign error          = error_q;
  assign error_pulse    = pulse_q;
  assign fault_count    = count_q;
  assign fault_snapshot = snap_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Bench for sensor_monitor: default instance plus a COUNT_W=2, DEBOUNCE_CYCLES=1 instance.
module tb_sensor_monitor;

  typedef struct {
    logic [7:0] cnt;
    logic [3:0] snap;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] sensors;
  logic [3:0] sensor_en;
  logic       clear;
  logic       error;
  logic       error_pulse;
  logic [7:0] fault_count;
  logic [3:0] fault_snapshot;

  logic [3:0] sensors_b;
  logic       clear_b;
  logic       error_b;
  logic       pulse_b;
  logic [1:0] count_b;
  logic [3:0] snap_b;

  int   total;
  int   bad;
  exp_t exp_q[$];

  sensor_monitor u_dut (
    .clk           (clk),
    .rst           (rst),
    .sensors       (sensors),
    .sensor_en     (sensor_en),
    .clear         (clear),
    .error         (error),
    .error_pulse   (error_pulse),
    .fault_count   (fault_count),
    .fault_snapshot(fault_snapshot)
  );

  sensor_monitor #(
    .COUNT_W        (2),
    .DEBOUNCE_CYCLES(1)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .sensors       (sensors_b),
    .sensor_en     (4'b1111),
    .clear         (clear_b),
    .error         (error_b),
    .error_pulse   (pulse_b),
    .fault_count   (count_b),
    .fault_snapshot(snap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; any entry pulse drains the scoreboard.
  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    if (error_pulse === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: got pulse count=%0d, required no pulse", fault_count);
      end else begin
        e = exp_q.pop_front();
        if (fault_count !== e.cnt || fault_snapshot !== e.snap) begin
          bad++;
          $display("FAIL entry: got count=%0d snap=%b, required count=%0d snap=%b",
                   fault_count, fault_snapshot, e.cnt, e.snap);
        end
      end
    end
  endtask

  task automatic go_idle;
    sensors = 4'b0000;
    clear   = 1'b1;
    repeat (4) tick();
    clear = 1'b0;
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL go_idle: got error=%b, required 0", error);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sensors = 4'b1111; sensor_en = 4'b1111; clear = 1'b0;
    sensors_b = 4'b0000; clear_b = 1'b0;
    repeat (3) tick();
    total++;
    if ({error, error_pulse, fault_count, fault_snapshot, error_b, pulse_b, count_b, snap_b}
        !== '0) begin
      bad++;
      $display("FAIL reset_state: got err=%b pul=%b cnt=%0d snap=%b, required all 0",
               error, error_pulse, fault_count, fault_snapshot);
    end
    exp_q.push_back('{cnt: 8'd1, snap: 4'b1111});
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (error !== (k == 5)) begin
        bad++;
        $display("FAIL reset_latency k=%0d: got error=%b, required %b", k, error, k == 5);
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if ({error, error_pulse, fault_count, fault_snapshot} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got err=%b cnt=%0d snap=%b, required 0", error, fault_count,
               fault_snapshot);
    end
    sensors = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_debounce;
    sensors = 4'b0001;
    repeat (3) begin
      tick();
      total++;
      if (error !== 1'b0) begin
        bad++;
        $display("FAIL short_fault: got error=%b, required 0", error);
      end
    end
    sensors = 4'b0000;
    repeat (4) begin
      tick();
      total++;
      if (error !== 1'b0) begin
        bad++;
        $display("FAIL short_fault_tail: got error=%b, required 0", error);
      end
    end
    exp_q.push_back('{cnt: 8'd1, snap: 4'b0110});
    sensors = 4'b0110;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (error !== (k >= 5) || error_pulse !== (k == 5)) begin
        bad++;
        $display("FAIL pair_fault k=%0d: got error=%b pulse=%b, required %b %b", k, error,
                 error_pulse, k >= 5, k == 5);
      end
    end
    go_idle();
  endtask

  task automatic test_no_pair;
    logic [3:0] pats [2];
    pats[0] = 4'b0010;
    pats[1] = 4'b1100;
    for (int p = 0; p < 2; p++) begin
      sensors = pats[p];
      repeat (10) begin
        tick();
        total++;
        if (error !== 1'b0) begin
          bad++;
          $display("FAIL no_pair %b: got error=%b, required 0", pats[p], error);
        end
      end
    end
    sensors = 4'b0000;
    repeat (2) tick();
  endtask

  task automatic test_clear;
    exp_q.push_back('{cnt: 8'd2, snap: 4'b0001});
    sensors = 4'b0001;
    repeat (6) tick();
    total++;
    if (error !== 1'b1 || fault_count !== 8'd2) begin
      bad++;
      $display("FAIL crit_fault: got error=%b cnt=%0d, required 1 2", error, fault_count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (2) tick();
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL clear_in_fault: got error=%b, required 1", error);
    end
    sensors = 4'b0000;
    repeat (2) tick();
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL latched_hold: got error=%b, required 1", error);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL latched_clear: got error=%b, required 0", error);
    end
  endtask

  task automatic test_latched_priority;
    exp_q.push_back('{cnt: 8'd3, snap: 4'b0001});
    sensors = 4'b0001;
    repeat (6) tick();
    sensors = 4'b0000;
    repeat (2) tick();
    sensors = 4'b1010;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (error !== 1'b1 || error_pulse !== 1'b0 || fault_count !== 8'd3) begin
        bad++;
        $display("FAIL raw_over_clear k=%0d: got err=%b pul=%b cnt=%0d, required 1 0 3", k,
                 error, error_pulse, fault_count);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_enable;
    sensor_en = 4'b1110;
    sensors   = 4'b0001;
    repeat (8) begin
      tick();
      total++;
      if (error !== 1'b0) begin
        bad++;
        $display("FAIL masked_crit: got error=%b, required 0", error);
      end
    end
    sensors   = 4'b0000;
    sensor_en = 4'b1111;
    repeat (2) tick();
  endtask

  task automatic test_clear_held;
    clear = 1'b1;
    exp_q.push_back('{cnt: 8'd4, snap: 4'b0110});
    sensors = 4'b0110;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (error !== (k == 5)) begin
        bad++;
        $display("FAIL clear_held_detect k=%0d: got error=%b, required %b", k, error, k == 5);
      end
    end
    sensors = 4'b0000;
    repeat (3) tick();
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL clear_held_release: got error=%b, required 0", error);
    end
    clear = 1'b0;
  endtask

  task automatic test_saturate_fast;
    logic [1:0] want;
    for (int n = 1; n <= 5; n++) begin
      want = (n < 3) ? 2'(n) : 2'd3;
      sensors_b = 4'b0001;
      tick();
      total++;
      if (error_b !== 1'b0) begin
        bad++;
        $display("FAIL fast_early n=%0d: got error=%b, required 0", n, error_b);
      end
      tick();
      total++;
      if (error_b !== 1'b1 || pulse_b !== 1'b1 || count_b !== want || snap_b !== 4'b0001) begin
        bad++;
        $display("FAIL fast_entry n=%0d: got err=%b pul=%b cnt=%0d snap=%b, required 1 1 %0d 0001",
                 n, error_b, pulse_b, count_b, snap_b, want);
      end
      sensors_b = 4'b0000;
      clear_b   = 1'b1;
      repeat (3) tick();
      clear_b = 1'b0;
      total++;
      if (error_b !== 1'b0) begin
        bad++;
        $display("FAIL fast_clear n=%0d: got error=%b, required 0", n, error_b);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_debounce();
    test_no_pair();
    test_clear();
    test_latched_priority();
    test_enable();
    test_clear_held();
    test_saturate_fast();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_entries: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
